seq_divider_hs: RTL and testbench

- Parametrised, iterative radix-2 restoring integer divider with ready/valid handshakes on input and output.
- Supports signed (truncating, C-style) and unsigned division, selected per operation.
- Flags divide-by-zero and signed overflow explicitly instead of corrupting outputs.
- Sits between an operand-issue stage and a result consumer in the datapath; at most one operation in flight.

---
 rtl/seq_divider_hs_pkg.sv | 23 ++
 rtl/seq_divider_hs_if.sv | 25 ++
 rtl/seq_divider_hs_step.sv | 26 ++
 rtl/seq_divider_hs.sv | 114 +++++++++++
 tb/tb_seq_divider_hs.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_hs_pkg.sv
// rtl/seq_divider_hs_pkg.sv - shared types, special-result encodings and helpers for the divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Encodings are kept wide and truncated to WIDTH where they are used.
    localparam logic [63:0] DBZ_QUOTIENT  = '1;
    localparam logic [63:0] OVF_REMAINDER = '0;

    // Magnitude of a w-bit value; unsigned operands pass through untouched.
    function automatic logic [63:0] abs_val(input logic [63:0] x, input logic is_signed,
                                            input int unsigned w);
        if (is_signed && x[w-1])
            return (64'd1 << w) - x;
        return x;
    endfunction

endpackage

// File: rtl/seq_divider_hs_if.sv
// rtl/seq_divider_hs_if.sv - operand request and result handshake bundle
interface seq_divider_hs_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, dividend, divisor, is_signed, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow, busy
    );

    modport slave (
        input  in_valid, dividend, divisor, is_signed, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow, busy
    );
endinterface

// File: rtl/seq_divider_hs_step.sv
// rtl/seq_divider_hs_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < dvs always holds, so the shifted remainder fits in WIDTH+1 bits.
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        if (!trial[WIDTH]) begin
            rem_out = trial[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = shifted[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/seq_divider_hs.sv
// rtl/seq_divider_hs.sv - iterative signed/unsigned divider with ready/valid handshakes
module seq_divider_hs
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_divider_hs_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state, state_nx;
    logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic [CNT_W-1:0] count;
    logic             quo_neg, rem_neg, dbz_r, ovf_r;
    logic             accept, is_zero, is_ovf;

    assign accept  = (state == IDLE) && bus.in_valid;
    assign is_zero = (bus.divisor == '0);
    assign is_ovf  = bus.is_signed && (bus.dividend == MIN_VAL) && (bus.divisor == '1);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_r),
        .quo_in  (quo_r),
        .dvs     (dvs_r),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (accept) state_nx = (is_zero || is_ovf) ? DONE : RUN;
            end
            RUN:  if (count == CNT_W'(1)) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r       <= '0;
            quo_r       <= '0;
            dvs_r       <= '0;
            count       <= '0;
            quo_neg     <= 1'b0;
            rem_neg     <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rem_r   <= '0;
                    quo_r   <= WIDTH'(abs_val(64'(bus.dividend), bus.is_signed, WIDTH));
                    dvs_r   <= WIDTH'(abs_val(64'(bus.divisor), bus.is_signed, WIDTH));
                    count   <= CNT_W'(WIDTH);
                    quo_neg <= bus.is_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    rem_neg <= bus.is_signed && bus.dividend[WIDTH-1];
                    // Special results bypass RUN and are written straight away.
                    if (is_zero) begin
                        quotient_r  <= WIDTH'(DBZ_QUOTIENT);
                        remainder_r <= bus.dividend;
                        dbz_r       <= 1'b1;
                        ovf_r       <= 1'b0;
                    end else if (is_ovf) begin
                        quotient_r  <= MIN_VAL;
                        remainder_r <= WIDTH'(OVF_REMAINDER);
                        dbz_r       <= 1'b0;
                        ovf_r       <= 1'b1;
                    end
                end
                RUN: begin
                    rem_r <= rem_nx;
                    quo_r <= quo_nx;
                    count <= count - CNT_W'(1);
                end
                FIX: begin
                    quotient_r  <= quo_neg ? -quo_r : quo_r;
                    remainder_r <= rem_neg ? -rem_r : rem_r;
                    dbz_r       <= 1'b0;
                    ovf_r       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.overflow    = ovf_r;
endmodule

// File: tb/tb_seq_divider_hs.sv
// tb/tb_seq_divider_hs.sv - directed self-checking bench for seq_divider_hs
module tb_seq_divider_hs;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    seq_divider_hs_if #(.WIDTH(8)) bus ();

    seq_divider_hs #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic start_op(input logic [7:0] dvd, input logic [7:0] dvs, input logic sgn,
                            output int lat);
        bus.dividend  = dvd;
        bus.divisor   = dvs;
        bus.is_signed = sgn;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: got v=%b b=%b r=%b want 0 0 1",
                     bus.out_valid, bus.busy, bus.in_ready);
        end
        checks++;
        if (bus.quotient !== 8'h00 || bus.remainder !== 8'h00 ||
            bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: got q=%h r=%h z=%b o=%b want 00 00 0 0",
                     bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_signed();
        logic [7:0] dvd [3] = '{8'hF9, 8'h07, 8'hF8};
        logic [7:0] dvs [3] = '{8'h02, 8'hFE, 8'hFD};
        logic [7:0] eq  [3] = '{8'hFD, 8'hFD, 8'h02};
        logic [7:0] er  [3] = '{8'hFF, 8'h01, 8'hFE};
        int lat;
        for (int i = 0; i < 3; i++) begin
            start_op(dvd[i], dvs[i], 1'b1, lat);
            checks++;
            if (lat !== 10 || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL signed_lat[%0d]: got %0d want 10", i, lat);
            end
            checks++;
            if (bus.quotient !== eq[i] || bus.remainder !== er[i] ||
                bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
                errors++;
                $display("FAIL signed[%0d]: got q=%h r=%h z=%b o=%b want %h %h 0 0", i,
                         bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow, eq[i], er[i]);
            end
            finish_op();
        end
    endtask

    task automatic test_unsigned();
        int lat;
        start_op(8'hC8, 8'h07, 1'b0, lat);
        checks++;
        if (lat !== 10 || bus.quotient !== 8'h1C || bus.remainder !== 8'h04 ||
            bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL unsigned_200_7: got lat=%0d q=%h r=%h o=%b want 10 1c 04 0",
                     lat, bus.quotient, bus.remainder, bus.overflow);
        end
        finish_op();
        start_op(8'h80, 8'hFF, 1'b0, lat);
        checks++;
        if (bus.quotient !== 8'h00 || bus.remainder !== 8'h80 ||
            bus.overflow !== 1'b0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL unsigned_80_ff: got q=%h r=%h o=%b z=%b want 00 80 0 0",
                     bus.quotient, bus.remainder, bus.overflow, bus.div_by_zero);
        end
        finish_op();
    endtask

    task automatic test_div_by_zero();
        int lat;
        start_op(8'h0D, 8'h00, 1'b0, lat);
        checks++;
        if (lat !== 1 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL dbz_lat: got %0d want 1", lat);
        end
        checks++;
        if (bus.quotient !== 8'hFF || bus.remainder !== 8'h0D ||
            bus.div_by_zero !== 1'b1 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL dbz: got q=%h r=%h z=%b o=%b want ff 0d 1 0",
                     bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        finish_op();
    endtask

    task automatic test_overflow();
        int lat;
        start_op(8'h80, 8'hFF, 1'b1, lat);
        checks++;
        if (lat !== 1 || bus.quotient !== 8'h80 || bus.remainder !== 8'h00 ||
            bus.overflow !== 1'b1 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL overflow: got lat=%0d q=%h r=%h o=%b z=%b want 1 80 00 1 0",
                     lat, bus.quotient, bus.remainder, bus.overflow, bus.div_by_zero);
        end
        finish_op();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad_busy = 0;
        int bad_hold = 0;
        bus.dividend  = 8'hC8;
        bus.divisor   = 8'h07;
        bus.is_signed = 1'b0;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.dividend = 8'h09;
        bus.divisor  = 8'h03;
        lat = 1;
        // Request stays raised while busy; it must neither be taken nor disturb the result.
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready !== 1'b0) bad_busy++;
            @(posedge clk);
            #1;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== 8'h1C ||
                bus.remainder !== 8'h04 || bus.div_by_zero !== 1'b0) bad_hold++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bad_busy != 0 || lat !== 10) begin
            errors++;
            $display("FAIL bp_busy: got bad=%0d lat=%0d want 0 10", bad_busy, lat);
        end
        checks++;
        if (bad_hold != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0", bad_hold);
        end
        finish_op();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.quotient !== 8'h1C ||
            bus.remainder !== 8'h04) begin
            errors++;
            $display("FAIL bp_release: got v=%b r=%b q=%h rem=%h want 0 1 1c 04",
                     bus.out_valid, bus.in_ready, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        bus.dividend  = 8'hF9;
        bus.divisor   = 8'h02;
        bus.is_signed = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
            bus.quotient !== 8'h00 || bus.remainder !== 8'h00 ||
            bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b r=%b b=%b q=%h rem=%h want 0 1 0 00 00",
                     bus.out_valid, bus.in_ready, bus.busy, bus.quotient, bus.remainder);
        end
        start_op(8'h09, 8'h03, 1'b0, lat);
        checks++;
        if (lat !== 10 || bus.quotient !== 8'h03 || bus.remainder !== 8'h00) begin
            errors++;
            $display("FAIL after_reset: got lat=%0d q=%h r=%h want 10 03 00",
                     lat, bus.quotient, bus.remainder);
        end
        finish_op();
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.is_signed = 1'b0;
        test_reset();
        test_signed();
        test_unsigned();
        test_div_by_zero();
        test_overflow();
        test_backpressure();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
